// File: rtl/updown_dir_decoder.sv
// rtl/updown_dir_decoder.sv - recovers count direction from an observed up/down counter bus
// Optional UPDOWN_DIR_STATS_EN adds saturating err_count/rev_count outputs.
module updown_dir_decoder #(
  parameter int WIDTH    = 4,
  parameter int LOCK_LEN = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  output logic             updown_out,
  output logic             dir_valid,
  output logic             dir_change,
  output logic             step_err,
  output logic             hold_seen,
  output logic [3:0]       run_len
`ifdef UPDOWN_DIR_STATS_EN
  ,
  output logic [7:0]       err_count,
  output logic [7:0]       rev_count
`endif
);

  typedef enum logic [1:0] {ACQ, TRK_UP, TRK_DN, FAULT} state_t;
  typedef enum logic [1:0] {ST_UP, ST_DN, ST_HOLD, ST_JUMP} step_t;

  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DN = {WIDTH{1'b1}};
  localparam logic [3:0]       RUN_MAX  = 4'd15;
  localparam logic [3:0]       LOCK_THR = 4'(LOCK_LEN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [3:0]       run_q, run_d;
  logic             ud_q, ud_d;
  logic             dv_q, dv_d;
  logic             dc_q, dc_d;
  logic             se_q, se_d;
  logic             hs_q, hs_d;
  logic [WIDTH-1:0] delta;
  step_t            step;

  // Modular difference makes max->0 an UP step and 0->max a DOWN step.
  always_comb begin
    delta = count_in - prev_q;
    if (delta == DELTA_UP)            step = ST_UP;
    else if (delta == DELTA_DN)       step = ST_DN;
    else if (delta == {WIDTH{1'b0}})  step = ST_HOLD;
    else                              step = ST_JUMP;
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    run_d   = run_q;
    ud_d    = ud_q;
    dc_d    = 1'b0;
    se_d    = 1'b0;
    hs_d    = 1'b0;
    if (sample_en) begin
      prev_d = count_in;
      case (state_q)
        ACQ: begin
          // Acquisition only establishes a reference; it never raises pulses.
          case (step)
            ST_UP: begin
              state_d = TRK_UP;
              run_d   = 4'd1;
            end
            ST_DN: begin
              state_d = TRK_DN;
              run_d   = 4'd1;
            end
            ST_JUMP: state_d = FAULT;
            default: state_d = ACQ;
          endcase
        end
        TRK_UP, TRK_DN: begin
          case (step)
            ST_UP, ST_DN: begin
              if ((state_q == TRK_UP) == (step == ST_UP)) begin
                run_d = (run_q == RUN_MAX) ? RUN_MAX : run_q + 4'd1;
              end else begin
                state_d = (step == ST_UP) ? TRK_UP : TRK_DN;
                run_d   = 4'd1;
                dc_d    = dv_q;
              end
            end
            ST_HOLD: hs_d = 1'b1;
            default: begin
              state_d = FAULT;
              run_d   = 4'd0;
              se_d    = 1'b1;
            end
          endcase
        end
        default: begin
          case (step)
            ST_UP: begin
              state_d = TRK_UP;
              run_d   = 4'd1;
            end
            ST_DN: begin
              state_d = TRK_DN;
              run_d   = 4'd1;
            end
            ST_HOLD: hs_d = 1'b1;
            default: se_d = 1'b1;
          endcase
        end
      endcase
    end
    if (state_d == TRK_UP)      ud_d = 1'b1;
    else if (state_d == TRK_DN) ud_d = 1'b0;
    dv_d = ((state_d == TRK_UP) || (state_d == TRK_DN)) && (run_d >= LOCK_THR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACQ;
      prev_q  <= '0;
      run_q   <= 4'd0;
      ud_q    <= 1'b0;
      dv_q    <= 1'b0;
      dc_q    <= 1'b0;
      se_q    <= 1'b0;
      hs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      run_q   <= run_d;
      ud_q    <= ud_d;
      dv_q    <= dv_d;
      dc_q    <= dc_d;
      se_q    <= se_d;
      hs_q    <= hs_d;
    end
  end

  assign updown_out = ud_q;
  assign dir_valid  = dv_q;
  assign dir_change = dc_q;
  assign step_err   = se_q;
  assign hold_seen  = hs_q;
  assign run_len    = run_q;

`ifdef UPDOWN_DIR_STATS_EN
  logic [7:0] err_q, rev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 8'd0;
      rev_q <= 8'd0;
    end else begin
      if (se_d && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
      if (dc_d && (rev_q != 8'hFF)) rev_q <= rev_q + 8'd1;
    end
  end

  assign err_count = err_q;
  assign rev_count = rev_q;
`endif

endmodule

// File: tb/tb_updown_dir_decoder.sv
// tb/tb_updown_dir_decoder.sv - scoreboard bench for updown_dir_decoder
// Stimulus pushes hand-computed responses; a negedge monitor pops and compares.
module tb_updown_dir_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sample_en = 1'b0;
  logic [3:0] count_in = 4'd0;
  logic       updown_out, dir_valid, dir_change, step_err, hold_seen;
  logic [3:0] run_len;
`ifdef UPDOWN_DIR_STATS_EN
  logic [7:0] err_count, rev_count;
`endif

  updown_dir_decoder #(.WIDTH(4), .LOCK_LEN(3)) dut (
    .clock      (clk),
    .reset      (reset),
    .sample_en  (sample_en),
    .count_in   (count_in),
    .updown_out (updown_out),
    .dir_valid  (dir_valid),
    .dir_change (dir_change),
    .step_err   (step_err),
    .hold_seen  (hold_seen),
    .run_len    (run_len)
`ifdef UPDOWN_DIR_STATS_EN
    ,
    .err_count  (err_count),
    .rev_count  (rev_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [8:0] v;
    logic [7:0] ec;
    logic [7:0] rc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_ec = 0;
  int   exp_rc = 0;

  task automatic apply(input string n, input bit r, input bit e, input int c,
                       input bit ud, input bit dv, input bit dc, input bit se,
                       input bit hs, input int rl);
    exp_t x;
    @(negedge clk);
    reset     = r;
    sample_en = e;
    count_in  = 4'(c);
    @(posedge clk);
    #1;
    if (r) begin
      exp_ec = 0;
      exp_rc = 0;
    end else begin
      exp_ec += int'(se);
      exp_rc += int'(dc);
    end
    x.name = n;
    x.v    = {ud, dv, dc, se, hs, 4'(rl)};
    x.ec   = 8'(exp_ec);
    x.rc   = 8'(exp_rc);
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      logic [8:0] got;
      x   = sb.pop_front();
      got = {updown_out, dir_valid, dir_change, step_err, hold_seen, run_len};
      n_vec++;
      if (got !== x.v) begin
        n_bad++;
        $display("FAIL %s: got {ud,dv,dc,se,hs,rl}=%b_%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%b_%0d",
                 x.name, got[8], got[7], got[6], got[5], got[4], got[3:0],
                 x.v[8], x.v[7], x.v[6], x.v[5], x.v[4], x.v[3:0]);
      end
`ifdef UPDOWN_DIR_STATS_EN
      if (err_count !== x.ec || rev_count !== x.rc) begin
        n_bad++;
        $display("FAIL %s_stats: got err=%0d rev=%0d expected err=%0d rev=%0d",
                 x.name, err_count, rev_count, x.ec, x.rc);
      end
`endif
    end
  end

  initial begin
    // T1: reset (wins over sample_en), acquisition, lock at run_len 3
    apply("rst0",     1, 0, 0,  0, 0, 0, 0, 0, 0);
    apply("rst1_en",  1, 1, 5,  0, 0, 0, 0, 0, 0);
    apply("acq_hold", 0, 1, 0,  0, 0, 0, 0, 0, 0);
    apply("t1_s1",    0, 1, 1,  1, 0, 0, 0, 0, 1);
    apply("t1_s2",    0, 1, 2,  1, 0, 0, 0, 0, 2);
    apply("t1_s3",    0, 1, 3,  1, 1, 0, 0, 0, 3);
    apply("t1_s4",    0, 1, 4,  1, 1, 0, 0, 0, 4);
    // T2: run to 15, wrap to 0,1 as UP with saturation
    for (int c = 5; c <= 15; c++)
      apply($sformatf("t2_up%0d", c), 0, 1, c, 1, 1, 0, 0, 0, c);
    apply("t2_wrap0", 0, 1, 0,  1, 1, 0, 0, 0, 15);
    apply("t2_wrap1", 0, 1, 1,  1, 1, 0, 0, 0, 15);
    for (int c = 2; c <= 5; c++)
      apply($sformatf("t3_up%0d", c), 0, 1, c, 1, 1, 0, 0, 0, 15);
    // T3: locked reversal pulses once, then relock; unlocked reversal is silent
    apply("t3_rev",   0, 1, 4,  0, 0, 1, 0, 0, 1);
    apply("t3_dn3",   0, 1, 3,  0, 0, 0, 0, 0, 2);
    apply("t3_unlk",  0, 1, 4,  1, 0, 0, 0, 0, 1);
    apply("t3_up5",   0, 1, 5,  1, 0, 0, 0, 0, 2);
    apply("t3_up6",   0, 1, 6,  1, 1, 0, 0, 0, 3);
    // T4: jump faults, fault jump/hold, recovery
    apply("t4_jump",  0, 1, 9,  1, 0, 0, 1, 0, 0);
    apply("t4_fjump", 0, 1, 13, 1, 0, 0, 1, 0, 0);
    apply("t4_fhold", 0, 1, 13, 1, 0, 0, 0, 1, 0);
    apply("t4_recov", 0, 1, 14, 1, 0, 0, 0, 0, 1);
    apply("t4_up15",  0, 1, 15, 1, 0, 0, 0, 0, 2);
    apply("t4_up0",   0, 1, 0,  1, 1, 0, 0, 0, 3);
    for (int c = 1; c <= 7; c++)
      apply($sformatf("t5_up%0d", c), 0, 1, c, 1, 1, 0, 0, 0, c + 3);
    // T5: hold during lock, disabled sample ignored, resume
    apply("t5_hold",  0, 1, 7,  1, 1, 0, 0, 1, 10);
    apply("t5_dis",   0, 0, 12, 1, 1, 0, 0, 0, 10);
    apply("t5_resume",0, 1, 8,  1, 1, 0, 0, 0, 11);
    // Down path via fault, 0->15 wrap as DOWN, locked down->up reversal
    apply("dn_jump",  0, 1, 0,  1, 0, 0, 1, 0, 0);
    apply("dn_wrap",  0, 1, 15, 0, 0, 0, 0, 0, 1);
    apply("dn_14",    0, 1, 14, 0, 0, 0, 0, 0, 2);
    apply("dn_13",    0, 1, 13, 0, 1, 0, 0, 0, 3);
    apply("dn_rev",   0, 1, 14, 1, 0, 1, 0, 0, 1);
    apply("up_15",    0, 1, 15, 1, 0, 0, 0, 0, 2);
    // T6: mid-run reset, then ACQ jump to FAULT without pulse, then DOWN
    apply("t6_rst",   1, 1, 15, 0, 0, 0, 0, 0, 0);
    apply("t6_acqj",  0, 1, 3,  0, 0, 0, 0, 0, 0);
    apply("t6_dn",    0, 1, 2,  0, 0, 0, 0, 0, 1);
    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
